cnt16: RTL and testbench

- Synchronous modulo-16 counter, 4-bit by default, used as a general tick/sequence counter in datapath and control logic.
- Counts up or down when enabled.
- Supports parallel load and wraps at the modulus boundaries.
- Provides a combinational terminal-count flag and a registered wrap pulse for cascading or event signalling.

---
 rtl/cnt16_pkg.sv | 20 ++
 rtl/cnt16.sv | 85 ++++++++
 tb/tb_cnt16.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cnt16_pkg.sv
// rtl/cnt16_pkg.sv - shared constants and encodings for the cnt16 counter
package cnt16_pkg;

    localparam int CNT16_WIDTH = 4;
    localparam int CNT16_MAX   = 15;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Next-state select, listed in descending priority
    typedef enum logic [1:0] {
        SEL_RST  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_HOLD = 2'd3
    } sel_e;

endpackage

// File: rtl/cnt16.sv
// rtl/cnt16.sv - modulo-(MAX+1) up/down counter with load, terminal count and wrap pulse
module cnt16
    import cnt16_pkg::*;
#(
    parameter int WIDTH = CNT16_WIDTH,
    parameter int MAX   = CNT16_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    dir_e             dir;
    sel_e             sel;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    assign dir     = dir_e'(up_dn);
    assign at_max  = (cnt == MAX_V);
    assign at_zero = (cnt == ZERO_V);

    always_comb begin
        sel = SEL_HOLD;
        if (rst) begin
            sel = SEL_RST;
        end else if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            sel = SEL_CNT;
        end
    end

    // tc flags the cycle whose edge will wrap, so it also drives the wrap pulse
    always_comb begin
        tc = 1'b0;
        if (en) begin
            tc = (dir == DIR_UP) ? at_max : at_zero;
        end
    end

    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    always_comb begin
        cnt_step = cnt;
        if (dir == DIR_UP) begin
            cnt_step = at_max ? ZERO_V : (cnt + ONE_V);
        end else begin
            cnt_step = at_zero ? MAX_V : (cnt - ONE_V);
        end
    end

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        case (sel)
            SEL_RST:  cnt_nxt = ZERO_V;
            SEL_LOAD: cnt_nxt = load_clamped;
            SEL_CNT: begin
                cnt_nxt  = cnt_step;
                wrap_nxt = tc;
            end
            default:  cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        cnt  <= cnt_nxt;
        wrap <= wrap_nxt;
    end

endmodule

// File: tb/tb_cnt16.sv
// tb/tb_cnt16.sv - vector table and scoreboard bench for cnt16
module tb_cnt16;

    typedef struct {
        logic       rst;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic       exp_wrap;
        logic       chk11;
        logic [3:0] exp_cnt11;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt;
    logic       tc;
    logic       wrap;
    logic [3:0] cnt11;
    logic       tc11;
    logic       wrap11;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #10 clk = ~clk;

    cnt16 dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt(cnt), .tc(tc), .wrap(wrap)
    );

    cnt16 #(.WIDTH(4), .MAX(11)) dut11 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cnt(cnt11), .tc(tc11), .wrap(wrap11)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                                input logic [3:0] lv, input logic [3:0] c, input logic t,
                                input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
        v.exp_cnt = c; v.exp_tc = t; v.exp_wrap = w; v.chk11 = 1'b0; v.exp_cnt11 = 4'd0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        rst = v.rst; en = v.en; up_dn = v.up_dn; load = v.load; load_val = v.load_val;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (cnt !== e.exp_cnt) begin
            n_bad++;
            $display("FAIL %s cnt: got %0d want %0d", name, cnt, e.exp_cnt);
        end
        if (tc !== e.exp_tc) begin
            n_bad++;
            $display("FAIL %s tc: got %b want %b (cnt=%0d)", name, tc, e.exp_tc, cnt);
        end
        if (wrap !== e.exp_wrap) begin
            n_bad++;
            $display("FAIL %s wrap: got %b want %b (cnt=%0d)", name, wrap, e.exp_wrap, cnt);
        end
        if (e.chk11 && (cnt11 !== e.exp_cnt11)) begin
            n_bad++;
            $display("FAIL %s cnt11: got %0d want %0d", name, cnt11, e.exp_cnt11);
        end
    endtask

    initial begin
        vec_t v;
        logic [3:0] m;
        logic [3:0] c;

        // reset with en high: no counting
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        // up count through the wrap
        for (int i = 1; i <= 17; i++) begin
            c = 4'(i % 16);
            vecs.push_back(mk(0, 1, 1, 0, 0, c, (c == 4'd15), (i == 16)));
        end
        // down count through the wrap
        vecs.push_back(mk(0, 0, 0, 1, 2, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 15, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 14, 0, 0));
        // load beats a simultaneous enable
        vecs.push_back(mk(0, 1, 1, 1, 9, 9, 0, 0));
        // hold, then direction toggling
        vecs.push_back(mk(0, 0, 1, 1, 7, 7, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8, 0, 0));

        foreach (vecs[i]) apply(vecs[i], "table");

        // reset at a pending wrap edge suppresses the pulse
        apply(mk(0, 1, 1, 1, 14, 14, 0, 0), "rst_mid_load");
        apply(mk(0, 1, 1, 0, 0, 15, 1, 0), "rst_mid_tc");
        apply(mk(1, 1, 1, 0, 0, 0, 0, 0), "rst_mid_rst");
        apply(mk(0, 1, 1, 0, 0, 1, 0, 0), "rst_mid_after");

        // load at a pending wrap edge suppresses the pulse
        apply(mk(0, 1, 1, 1, 15, 15, 1, 0), "ld_mid_load");
        apply(mk(0, 1, 1, 1, 3, 3, 0, 0), "ld_mid_reload");
        apply(mk(0, 0, 1, 0, 0, 3, 0, 0), "ld_mid_after");

        // clamp on the MAX=11 instance
        v = mk(0, 0, 1, 1, 14, 14, 0, 0); v.chk11 = 1'b1; v.exp_cnt11 = 4'd11;
        apply(v, "clamp14");
        v = mk(0, 0, 1, 1, 11, 11, 0, 0); v.chk11 = 1'b1; v.exp_cnt11 = 4'd11;
        apply(v, "clamp11");
        v = mk(0, 0, 1, 1, 5, 5, 0, 0); v.chk11 = 1'b1; v.exp_cnt11 = 4'd5;
        apply(v, "clamp5");
        v = mk(0, 0, 1, 1, 12, 12, 0, 0); v.chk11 = 1'b1; v.exp_cnt11 = 4'd11;
        apply(v, "clamp12");

        // random traffic against a reference model of the default counter
        m = 4'd12;
        for (int i = 0; i < 300; i++) begin
            v.rst = ($urandom_range(0, 31) == 0);
            v.load = ($urandom_range(0, 7) == 0);
            v.en = ($urandom_range(0, 3) != 0);
            v.up_dn = 1'($urandom_range(0, 1));
            v.load_val = 4'($urandom_range(0, 15));
            v.chk11 = 1'b0;
            v.exp_cnt11 = 4'd0;
            v.exp_wrap = 1'b0;
            if (v.rst) begin
                m = 4'd0;
            end else if (v.load) begin
                m = v.load_val;
            end else if (v.en) begin
                if (v.up_dn) begin
                    v.exp_wrap = (m == 4'd15);
                    m = (m == 4'd15) ? 4'd0 : m + 4'd1;
                end else begin
                    v.exp_wrap = (m == 4'd0);
                    m = (m == 4'd0) ? 4'd15 : m - 4'd1;
                end
            end
            v.exp_cnt = m;
            v.exp_tc = v.en && (v.up_dn ? (m == 4'd15) : (m == 4'd0));
            apply(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
